// File: rtl/cache_l1_param_if.sv
// cache_l1_param_if: CPU load/store and memory-bus signals of the L1 cache
interface cache_l1_param_if #(parameter int ADDR_W = 10);
  logic              rd_en;
  logic              wr_en;
  logic              flush;
  logic [2:0]        mask;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
  modport slave (
    input  rd_en, wr_en, flush, mask, addr, wdata, mem_rdata, mem_ack,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, hit_cnt, miss_cnt
  );
  modport master (
    output rd_en, wr_en, flush, mask, addr, wdata, mem_rdata, mem_ack,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_l1_param.sv
// cache_l1_param: direct-mapped write-through L1 cache; CACHE_L1_STATS_EN enables hit/miss counters
module cache_l1_param #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 6
) (
  input logic             clk,
  input logic             reset,
  cache_l1_param_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  state_t             r_state, w_next;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];
  logic [31:0]        r_data [LINES];
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic [INDEX_W-1:0] w_idx, w_ridx;
  logic [TAG_W-1:0]   w_tag, w_rtag;
  logic [1:0]         w_off;
  logic [31:0]        w_line, w_ld_data, w_wrep;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [3:0]         w_wstrb;
  logic               w_idle, w_hit_line, w_st_ok, w_flush, w_store, w_load, w_rhit, w_rmiss, w_fill, w_merge;
  assign w_idx      = bus.addr[INDEX_W+1:2];
  assign w_tag      = bus.addr[ADDR_W-1:INDEX_W+2];
  assign w_off      = bus.addr[1:0];
  assign w_ridx     = r_addr[INDEX_W+1:2];
  assign w_rtag     = r_addr[ADDR_W-1:INDEX_W+2];
  assign w_line     = r_data[w_idx];
  assign w_hit_line = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle     = (r_state == IDLE);
  assign w_st_ok    = (bus.mask == 3'b000) || (bus.mask == 3'b001) || (bus.mask == 3'b010);
  // flush outranks stores, and stores outrank loads
  assign w_flush    = w_idle && bus.flush;
  assign w_store    = w_idle && !bus.flush && bus.wr_en && w_st_ok;
  assign w_load     = w_idle && !bus.flush && bus.rd_en && !bus.wr_en;
  assign w_rhit     = w_load && w_hit_line;
  assign w_rmiss    = w_load && !w_hit_line;
  assign w_fill     = (r_state == REFILL) && bus.mem_ack;
  assign w_merge    = w_store && w_hit_line;
  assign w_byte     = w_line[{w_off, 3'b000} +: 8];
  assign w_half     = bus.addr[1] ? w_line[31:16] : w_line[15:0];
  assign w_ld_data  = (bus.mask == 3'b000) ? {{24{w_byte[7]}}, w_byte} :
                      (bus.mask == 3'b001) ? {{16{w_half[15]}}, w_half} :
                      (bus.mask == 3'b010) ? w_line :
                      (bus.mask == 3'b100) ? {24'b0, w_byte} :
                      (bus.mask == 3'b101) ? {16'b0, w_half} : 32'b0;
  assign w_wrep     = (bus.mask[1:0] == 2'b00) ? {4{bus.wdata[7:0]}} :
                      (bus.mask[1:0] == 2'b01) ? {2{bus.wdata[15:0]}} : bus.wdata;
  assign w_wstrb    = (bus.mask[1:0] == 2'b00) ? 4'b0001 << w_off :
                      (bus.mask[1:0] == 2'b01) ? 4'b0011 << {bus.addr[1], 1'b0} : 4'hF;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_next;
      if (w_flush) r_valid <= '0;
      else if (w_fill) r_valid[w_ridx] <= 1'b1;
      if (w_rmiss || w_store) r_addr <= {bus.addr[ADDR_W-1:2], 2'b00};
      if (w_store) begin
        r_wdata <= w_wrep;
        r_wstrb <= w_wstrb;
      end
    end
  end
  // data and tags need no reset: the valid bits alone decide what is cached
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_ridx] <= bus.mem_rdata;
      r_tag[w_ridx]  <= w_rtag;
    end else if (w_merge) begin
      for (int b = 0; b < 4; b++)
        if (w_wstrb[b]) r_data[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
    end
  end
  always_comb begin
    w_next        = r_state;
    bus.stall     = 1'b0;
    bus.rdata     = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wstrb = '0;
    case (r_state)
      IDLE: begin
        bus.stall = w_flush || w_store || w_rmiss;
        bus.rdata = w_rhit ? w_ld_data : '0;
        w_next    = w_store ? WRITE : w_rmiss ? REFILL : IDLE;
      end
      REFILL: begin
        bus.mem_req = 1'b1;
        bus.stall   = 1'b1;
        w_next      = bus.mem_ack ? IDLE : REFILL;
      end
      WRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wstrb = r_wstrb;
        bus.stall     = !bus.mem_ack;
        w_next        = bus.mem_ack ? IDLE : WRITE;
      end
      default: w_next = IDLE;
    endcase
  end
`ifdef CACHE_L1_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_rhit && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_rmiss && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_l1_param.sv
// tb_cache_l1_param: directed vector table plus flush/reset corner sequences for cache_l1_param
module tb_cache_l1_param;
`ifdef CACHE_L1_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  m;
    logic [9:0]  a;
    logic [31:0] wd;
    int          dly;
    int          nst;
    logic        req;
    logic [31:0] rdat;
    logic [3:0]  st;
    logic [31:0] wdat;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int pass = 0;
  int total = 0;
  logic [31:0] mem [256];
  vec_t tbl [17];
  cache_l1_param_if #(.ADDR_W(10)) bus ();
  cache_l1_param #(.ADDR_W(10), .INDEX_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic xact(input vec_t v, output int nst, output logic req, output logic [31:0] rd,
                      output logic [9:0] ma, output logic [3:0] st, output logic [31:0] wd,
                      output logic stable, output logic done);
    int cnt = 0;
    bus.rd_en = v.rd; bus.wr_en = v.wr; bus.mask = v.m; bus.addr = v.a; bus.wdata = v.wd;
    nst = 0; req = 1'b0; rd = '0; ma = '0; st = '0; wd = '0; stable = 1'b1; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (!req) begin
          ma = bus.mem_addr; st = bus.mem_wstrb; wd = bus.mem_wdata;
        end else if (bus.mem_addr !== ma || bus.mem_wstrb !== st || bus.mem_wdata !== wd) stable = 1'b0;
        req = 1'b1;
        cnt++;
        bus.mem_rdata = mem[bus.mem_addr[9:2]];
        bus.mem_ack = (cnt > v.dly);
      end
      #1;
      if (bus.mem_ack && bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      if (bus.stall) nst++;
      else begin
        rd = bus.rdata;
        done = 1'b1;
      end
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
    end
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
  endtask
  initial begin
    int nst;
    logic req, stable, done;
    logic [31:0] rd, wd;
    logic [9:0] ma;
    logic [3:0] st;
    vec_t v;
    tbl[0]  = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0,        0, 2, 1'b1, 32'h8000_00F1, 4'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 10'h013, 32'h0,        0, 0, 1'b0, 32'hFFFF_FF80, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 3'b100, 10'h010, 32'h0,        0, 0, 1'b0, 32'h0000_00F1, 4'h0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'b001, 10'h012, 32'h0,        0, 0, 1'b0, 32'hFFFF_8000, 4'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'b101, 10'h010, 32'h0,        0, 0, 1'b0, 32'h0000_00F1, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 3'b011, 10'h010, 32'h0,        0, 0, 1'b0, 32'h0,         4'h0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'b000, 10'h011, 32'hAB,       3, 4, 1'b1, 32'h0,         4'b0010, 32'hABAB_ABAB};
    tbl[7]  = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0,        0, 0, 1'b0, 32'h8000_ABF1, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 3'b001, 10'h012, 32'h1234,     0, 1, 1'b1, 32'h0,         4'b1100, 32'h1234_1234};
    tbl[9]  = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0,        0, 0, 1'b0, 32'h1234_ABF1, 4'h0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 3'b010, 10'h200, 32'hCAFE_F00D, 1, 2, 1'b1, 32'h0,        4'hF, 32'hCAFE_F00D};
    tbl[11] = '{1'b1, 1'b0, 3'b010, 10'h200, 32'h0,        0, 2, 1'b1, 32'hCAFE_F00D, 4'h0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0,        0, 0, 1'b0, 32'h1234_ABF1, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 3'b100, 10'h010, 32'hFF,       0, 0, 1'b0, 32'h0,         4'h0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0,        0, 0, 1'b0, 32'h1234_ABF1, 4'h0, 32'h0};
    tbl[15] = '{1'b1, 1'b1, 3'b010, 10'h014, 32'h55,       0, 1, 1'b1, 32'h0,         4'hF, 32'h0000_0055};
    tbl[16] = '{1'b1, 1'b0, 3'b010, 10'h014, 32'h0,        0, 2, 1'b1, 32'h0000_0055, 4'h0, 32'h0};
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h8000_00F1;
    mem[8'h80] = 32'h1234_5678;
    reset = 1'b1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.flush = 1'b0; bus.mask = 3'b0;
    bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_we", bus.mem_we, 0);
    chk("reset mem_wstrb", bus.mem_wstrb, 0);
    chk("reset stall", bus.stall, 0);
    chk("reset hit_cnt", bus.hit_cnt, 0);
    chk("reset miss_cnt", bus.miss_cnt, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      v = tbl[i];
      xact(v, nst, req, rd, ma, st, wd, stable, done);
      chk($sformatf("row%0d done", i), done, 1);
      chk($sformatf("row%0d stall_cycles", i), nst, v.nst);
      chk($sformatf("row%0d mem_req_seen", i), req, v.req);
      if (v.rd && !v.wr) chk($sformatf("row%0d rdata", i), rd, v.rdat);
      if (v.req) chk($sformatf("row%0d mem_addr", i), ma, v.a & 10'h3FC);
      if (v.wr && v.req) begin
        chk($sformatf("row%0d mem_wstrb", i), st, v.st);
        chk($sformatf("row%0d mem_wdata", i), wd, v.wdat);
        chk($sformatf("row%0d write_stable", i), stable, 1);
      end
      if (i == 0) begin
        chk("first miss_cnt", bus.miss_cnt, STATS ? 32'd1 : 32'd0);
        chk("first hit_cnt", bus.hit_cnt, STATS ? 32'd1 : 32'd0);
      end
      if (i == 4) begin
        chk("row4 miss_cnt", bus.miss_cnt, STATS ? 32'd1 : 32'd0);
        chk("row4 hit_cnt", bus.hit_cnt, STATS ? 32'd5 : 32'd0);
      end
    end
    bus.flush = 1'b1;
    @(negedge clk);
    #1;
    chk("flush idle stall", bus.stall, 1);
    chk("flush idle mem_req", bus.mem_req, 0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    v = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 0, 2, 1'b1, 32'h1234_ABF1, 4'h0, 32'h0};
    xact(v, nst, req, rd, ma, st, wd, stable, done);
    chk("post-flush stall_cycles", nst, 2);
    chk("post-flush mem_req_seen", req, 1);
    chk("post-flush rdata", rd, 32'h1234_ABF1);
    bus.wr_en = 1'b1; bus.mask = 3'b010; bus.addr = 10'h010; bus.wdata = 32'h1122_3344;
    @(negedge clk);
    #1 chk("wflush idle stall", bus.stall, 1);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    #1;
    chk("wflush write mem_we", bus.mem_we, 1);
    chk("wflush write stall", bus.stall, 1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.mem_ack = 1'b1;
    mem[4] = 32'h1122_3344;
    @(negedge clk);
    #1 chk("wflush ack stall", bus.stall, 0);
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    bus.wr_en = 1'b0;
    v = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 0, 0, 1'b0, 32'h1122_3344, 4'h0, 32'h0};
    xact(v, nst, req, rd, ma, st, wd, stable, done);
    chk("wflush kept stall_cycles", nst, 0);
    chk("wflush kept rdata", rd, 32'h1122_3344);
    bus.rd_en = 1'b1; bus.mask = 3'b010; bus.addr = 10'h200;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1 chk("refill mem_req", bus.mem_req, 1);
    reset = 1'b1;
    bus.rd_en = 1'b0;
    #1;
    chk("async reset mem_req", bus.mem_req, 0);
    chk("async reset stall", bus.stall, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("late ack mem_req", bus.mem_req, 0);
    chk("late ack stall", bus.stall, 0);
    chk("late ack miss_cnt", bus.miss_cnt, 0);
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    v = '{1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 0, 2, 1'b1, 32'h1122_3344, 4'h0, 32'h0};
    xact(v, nst, req, rd, ma, st, wd, stable, done);
    chk("post-reset stall_cycles", nst, 2);
    chk("post-reset mem_req_seen", req, 1);
    chk("post-reset rdata", rd, 32'h1122_3344);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
